// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants for the key schedule,
// keystream/decrypt stage and key-search controller.
package rc4_pkg;

  localparam int S_DEPTH   = 256;
  localparam int KEYLENGTH = 3;

  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_WAIT_SI,
    ST_LATCH_SI,
    ST_SET_J,
    ST_WAIT_SJ,
    ST_LATCH_SJ,
    ST_WR_I,
    ST_WR_J,
    ST_SET_F,
    ST_WAIT_F,
    ST_LATCH_F,
    ST_WR_DEC,
    ST_CHECK,
    ST_DONE
  } prga_state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Legal plaintext byte test: 'a'..'z' or space.
// Shared with the key-search controller.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       legal_o
);

  logic in_az;
  logic is_sp;

  assign in_az = (byte_i >= ASCII_LO)
              && (byte_i <= ASCII_HI);
  assign is_sp = (byte_i == ASCII_SP);

  assign legal_o = in_az || is_sp;

endmodule

// File: rtl/rc4_decrypt.sv
// RC4 PRGA stage: walks shuffled S, XORs keystream with
// the encrypted ROM, writes plaintext and flags bad keys.
module rc4_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN        = 32,
  parameter bit KEYSTREAM_ONLY = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [7:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren,
  output logic       busy,
  output logic       done,
  output logic       key_valid
);

  localparam int N_BYTES =
    (MSG_LEN > S_DEPTH) ? S_DEPTH : MSG_LEN;
  localparam logic [8:0] LAST_K = 9'(N_BYTES - 1);

  prga_state_t state_q, state_d;

  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [8:0] k_q, k_d;
  logic [7:0] pt_q, pt_d;

  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_data_q, s_data_d;
  logic       s_wren_q, s_wren_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic [7:0] dec_addr_q, dec_addr_d;
  logic [7:0] dec_data_q, dec_data_d;
  logic       dec_wren_q, dec_wren_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       kv_q, kv_d;

  logic       legal;
  logic [7:0] plain;
  logic [7:0] f_idx;

  rc4_char_check u_chk (
    .byte_i  (pt_q),
    .legal_o (legal)
  );

  assign plain = s_q ^ rom_q;
  assign f_idx = si_q + sj_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      k_q        <= '0;
      pt_q       <= '0;
      s_addr_q   <= '0;
      s_data_q   <= '0;
      s_wren_q   <= 1'b0;
      rom_addr_q <= '0;
      dec_addr_q <= '0;
      dec_data_q <= '0;
      dec_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      kv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      pt_q       <= pt_d;
      s_addr_q   <= s_addr_d;
      s_data_q   <= s_data_d;
      s_wren_q   <= s_wren_d;
      rom_addr_q <= rom_addr_d;
      dec_addr_q <= dec_addr_d;
      dec_data_q <= dec_data_d;
      dec_wren_q <= dec_wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      kv_q       <= kv_d;
    end
  end

  // Outputs are registered, so each state's bus values
  // are loaded on the transition into that state.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    k_d        = k_q;
    pt_d       = pt_q;
    s_addr_d   = s_addr_q;
    s_data_d   = s_data_q;
    s_wren_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    dec_addr_d = dec_addr_q;
    dec_data_d = dec_data_q;
    dec_wren_d = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    kv_d       = kv_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_INC_I;
          i_d      = 8'd1;
          j_d      = '0;
          k_d      = '0;
          s_addr_d = 8'd1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          kv_d     = 1'b0;
        end
      end
      ST_INC_I:   state_d = ST_WAIT_SI;
      ST_WAIT_SI: state_d = ST_LATCH_SI;
      ST_LATCH_SI: begin
        state_d  = ST_SET_J;
        si_d     = s_q;
        j_d      = j_q + s_q;
        s_addr_d = j_q + s_q;
      end
      ST_SET_J:   state_d = ST_WAIT_SJ;
      ST_WAIT_SJ: state_d = ST_LATCH_SJ;
      ST_LATCH_SJ: begin
        state_d  = ST_WR_I;
        sj_d     = s_q;
        s_addr_d = i_q;
        s_data_d = s_q;
        s_wren_d = 1'b1;
      end
      ST_WR_I: begin
        state_d  = ST_WR_J;
        s_addr_d = j_q;
        s_data_d = si_q;
        s_wren_d = 1'b1;
      end
      ST_WR_J: begin
        state_d    = ST_SET_F;
        s_addr_d   = f_idx;
        rom_addr_d = k_q[7:0];
      end
      ST_SET_F:  state_d = ST_WAIT_F;
      ST_WAIT_F: state_d = ST_LATCH_F;
      ST_LATCH_F: begin
        state_d    = ST_WR_DEC;
        pt_d       = plain;
        dec_addr_d = k_q[7:0];
        dec_data_d = KEYSTREAM_ONLY ? s_q : plain;
        dec_wren_d = 1'b1;
      end
      ST_WR_DEC: state_d = ST_CHECK;
      ST_CHECK: begin
        if (!legal || k_q == LAST_K) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = legal;
        end else begin
          state_d  = ST_INC_I;
          i_d      = i_q + 8'd1;
          s_addr_d = i_q + 8'd1;
          k_d      = k_q + 9'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_address   = s_addr_q;
  assign s_data      = s_data_q;
  assign s_wren      = s_wren_q;
  assign rom_address = rom_addr_q;
  assign dec_address = dec_addr_q;
  assign dec_data    = dec_data_q;
  assign dec_wren    = dec_wren_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign key_valid   = kv_q;

endmodule

// File: tb/tb_rc4_decrypt.sv
// Randomized bench for rc4_decrypt against an array-level
// RC4 model with behavioural S, ROM and dec memories.
module tb_rc4_decrypt;

  localparam int MLEN  = 32;
  localparam int LIMIT = 13 * MLEN + 40;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] s_address, s_data, s_q;
  logic       s_wren;
  logic [7:0] rom_address, rom_q;
  logic [7:0] dec_address, dec_data;
  logic       dec_wren;
  logic       busy, done, key_valid;

  logic [7:0] s_mem   [256];
  logic [7:0] rom_mem [256];
  logic [7:0] dec_mem [256];
  logic [7:0] s_ar, rom_ar;
  logic [15:0] wq_act[$];

  logic [7:0] pt     [MLEN];
  logic [7:0] exp_s  [256];
  logic [15:0] exp_wr[$];
  int          exp_cnt;
  bit          exp_kv;

  int n_chk  = 0;
  int n_pass = 0;

  always #10 clk = ~clk;

  rc4_decrypt #(.MSG_LEN(MLEN), .KEYSTREAM_ONLY(1'b0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .s_address   (s_address),
    .s_data      (s_data),
    .s_wren      (s_wren),
    .s_q         (s_q),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .dec_address (dec_address),
    .dec_data    (dec_data),
    .dec_wren    (dec_wren),
    .busy        (busy),
    .done        (done),
    .key_valid   (key_valid)
  );

  // Single-port synchronous memories, registered address
  always @(posedge clk) begin
    if (s_wren) begin
      s_mem[s_address] = s_data;
      wq_act.push_back({s_address, s_data});
    end
    if (dec_wren) dec_mem[dec_address] = dec_data;
    s_ar   <= s_address;
    rom_ar <= rom_address;
  end
  assign s_q   = s_mem[s_ar];
  assign rom_q = rom_mem[rom_ar];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic bit is_legal(input logic [7:0] c);
    return (c >= "a" && c <= "z") || c == " ";
  endfunction

  function automatic logic [7:0] rnd_legal();
    int r = int'($urandom_range(0, 26));
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rnd_bad();
    logic [7:0] c;
    do c = 8'($urandom); while (is_legal(c));
    return c;
  endfunction

  task automatic gen_pt(input int bad);
    for (int k = 0; k < MLEN; k++) pt[k] = rnd_legal();
    if (bad >= 0) pt[bad] = rnd_bad();
  endtask

  task automatic s_identity();
    for (int a = 0; a < 256; a++) s_mem[a] = 8'(a);
  endtask

  task automatic s_perm();
    logic [7:0] t;
    int r;
    s_identity();
    for (int a = 255; a > 0; a--) begin
      r = int'($urandom_range(0, a));
      t = s_mem[a];
      s_mem[a] = s_mem[r];
      s_mem[r] = t;
    end
  endtask

  // Builds the ciphertext from pt and predicts the run
  task automatic model();
    logic [7:0] ms [256];
    logic [7:0] i, j, si, sj, idx, f;
    for (int a = 0; a < 256; a++) ms[a] = s_mem[a];
    exp_cnt = MLEN;
    exp_kv  = 1'b1;
    for (int k = 0; k < MLEN; k++)
      if (!is_legal(pt[k])) begin
        exp_cnt = k + 1;
        exp_kv  = 1'b0;
        break;
      end
    exp_wr.delete();
    i = 0;
    j = 0;
    for (int k = 0; k < MLEN; k++) begin
      i = i + 8'd1;
      si = ms[i];
      j = j + si;
      sj = ms[j];
      ms[i] = sj;
      ms[j] = si;
      idx = si + sj;
      f = ms[idx];
      rom_mem[k] = pt[k] ^ f;
      if (k < exp_cnt) begin
        exp_wr.push_back({i, sj});
        exp_wr.push_back({j, si});
      end
      if (k == exp_cnt - 1)
        for (int a = 0; a < 256; a++) exp_s[a] = ms[a];
    end
  endtask

  task automatic run(input string tag, input bit poke);
    int n, bad_s, bad_w;
    bit drop;
    model();
    for (int a = 0; a < 256; a++) dec_mem[a] = 8'hEE;
    wq_act.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "/busy_rise"}, 64'(busy), 64'd1);
    chk({tag, "/done_clr"}, 64'({done, key_valid}), 64'd0);
    n = 0;
    drop = 1'b0;
    while (!done && n < LIMIT) begin
      start = (poke && n == 4);
      @(posedge clk);
      n++;
      #1;
      if (!busy && !done) drop = 1'b1;
    end
    start = 1'b0;
    chk({tag, "/cycles"}, 64'(n), 64'(13 * exp_cnt));
    chk({tag, "/busy_fall"}, 64'(busy), 64'd0);
    chk({tag, "/busy_held"}, 64'(drop), 64'd0);
    chk({tag, "/key_valid"}, 64'(key_valid), 64'(exp_kv));
    for (int k = 0; k < exp_cnt; k++)
      chk($sformatf("%s/dec%0d", tag, k),
          64'(dec_mem[k]), 64'(pt[k]));
    if (exp_cnt < MLEN)
      chk({tag, "/dec_untouched"},
          64'(dec_mem[exp_cnt]), 64'hEE);
    bad_s = 0;
    for (int a = 0; a < 256; a++)
      if (s_mem[a] !== exp_s[a]) bad_s++;
    chk({tag, "/s_final"}, 64'(bad_s), 64'd0);
    chk({tag, "/s_nwr"}, 64'(wq_act.size()),
        64'(exp_wr.size()));
    bad_w = 0;
    for (int w = 0; w < exp_wr.size(); w++)
      if (w >= wq_act.size() || wq_act[w] !== exp_wr[w])
        bad_w++;
    chk({tag, "/s_writes"}, 64'(bad_w), 64'd0);
  endtask

  function automatic logic [63:0] outs();
    return 64'({s_address, s_data, s_wren, rom_address,
                dec_address, dec_data, dec_wren,
                busy, done, key_valid});
  endfunction

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    s_identity();
    for (int a = 0; a < 256; a++) begin
      rom_mem[a] = '0;
      dec_mem[a] = 8'hEE;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity S, all-'a' plaintext: enc[0]=63, enc[1]=64
    for (int k = 0; k < MLEN; k++) pt[k] = 8'h61;
    run("ident", 1'b0);
    chk("ident/dec0", 64'(dec_mem[0]), 64'h61);
    chk("ident/dec1", 64'(dec_mem[1]), 64'h61);

    // Abort on byte 1 ('A')
    s_identity();
    for (int k = 0; k < MLEN; k++) pt[k] = 8'h61;
    pt[1] = 8'h41;
    run("abort1", 1'b0);
    chk("abort1/dec1", 64'(dec_mem[1]), 64'h41);
    chk("abort1/S2", 64'(s_mem[2]), 64'd3);
    chk("abort1/S3", 64'(s_mem[3]), 64'd2);

    // Abort on the first byte
    s_identity();
    for (int k = 0; k < MLEN; k++) pt[k] = 8'h61;
    pt[0] = 8'h46;
    run("abort0", 1'b0);

    for (int r = 0; r < 8; r++) begin
      s_perm();
      gen_pt((r % 2 == 1) ?
             int'($urandom_range(0, MLEN - 1)) : -1);
      run($sformatf("rnd%0d", r), r == 2 || r == 5);
    end

    // Reset mid-run, then restart on the modified S
    s_perm();
    gen_pt(-1);
    model();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (98) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("midrst/outs", outs(), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst/idle", 64'({busy, done, s_wren}), 64'd0);
    gen_pt(-1);
    run("restart", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
